ipu_frame_sequencer: RTL
========================

Name: ipu_frame_sequencer

Overview:
- Parametrised image-processing-unit (IPU) sequencer.
- Scans a full frame, preloads the line buffers, and issues one convolution instruction per output pixel to the convolution coprocessor.
- Saturates each coprocessor result to 8 bits and hands it to the VGA write path over a valid/ready handshake.
- Supersedes the fixed 512x480 inline scan logic. Adds configurable frame geometry, kernel-size-dependent preload, per-frame mode, result saturation, abort, and a frame counter.

Parameters:
- IMG_W, 512, frame width in pixels.
- IMG_H, 480, frame height in lines.
- COORD_W, 9, width of the h/v coordinates; 2*COORD_W+4 <= 32.
- PIX_PER_WORD, 4, pixels per memory word (h step during buffer load).
- CONV_OP, 4'b0101, mode code that selects result[15:0]; any other mode selects result[31:16].

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  level request to process one frame
- size  in  2  kernel size code; rows preloaded K = size+2
- mode  in  4  coprocessor opcode placed in inst[3:0]
- abort  in  1  cancel the frame in progress
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a frame completes
- frame_count  out  8  completed frames, wraps at 255
- buf_start  out  1  line-buffer load enable
- buf_h  out  COORD_W  line-buffer column
- buf_v  out  COORD_W  line-buffer row
- cop_req  out  1  coprocessor request
- cop_inst  out  32  {zeros, v, h, mode}
- cop_wait  in  1  coprocessor busy
- cop_done  in  1  coprocessor result valid
- cop_result  in  32  coprocessor result
- pix_valid  out  1  output pixel valid
- pix_data  out  8  output pixel value
- pix_ready  in  1  VGA RAM write accepted

Behaviour:
- Reset (asynchronous): state=IDLE, all outputs 0, internal counters 0, start latch cleared.
- IDLE
  - Accept start=1 only when the armed latch is clear. On accept: latch size and mode, set the latch, clear all counters, go to PRELOAD.
  - The latch clears only while start=0, so a held start runs exactly one frame.
- PRELOAD
  - buf_start=1 every cycle.
  - buf_h advances by PIX_PER_WORD each cycle.
  - At buf_h = IMG_W-PIX_PER_WORD: buf_h<=0, buf_v<=buf_v+1, rows_loaded increments.
  - When rows_loaded reaches K, go to ISSUE with buf_start=0.
  - Total duration: K*IMG_W/PIX_PER_WORD cycles.
- ISSUE
  - While cop_wait=1, hold.
  - When cop_wait=0: cop_req<=1, cop_inst<={v_conv,h_conv,mode}, go to WAIT_RES.
  - cop_inst is stable while cop_req=1.
- WAIT_RES
  - cop_req stays high until cop_done=1.
  - On cop_done=1: cop_req<=0, capture the result field (mode==CONV_OP ? result[15:0] : result[31:16]), go to OUTPUT.
- Saturation: the captured field is treated as signed 16-bit.
  - Negative -> 0.
  - Greater than 255 -> 255.
  - Otherwise the low byte.
- OUTPUT
  - pix_valid=1; pix_data is held constant until pix_ready=1.
  - On pix_ready=1, pix_valid<=0, then:
    - If h_conv < IMG_W-1: h_conv+1, go to ISSUE.
    - If h_conv = IMG_W-1 and v_conv = IMG_H-1: go to DONE.
    - If h_conv = IMG_W-1 otherwise: h_conv<=0, v_conv+1, go to ROWLOAD.
- ROWLOAD
  - Loads exactly one row at buf_v; buf_v continues from its previous value and is not reset.
  - Rows are loaded only while buf_v < IMG_H. Once buf_v = IMG_H, ROWLOAD takes 1 cycle with buf_start=0.
  - Then go to ISSUE.
- DONE: done=1 for one cycle, frame_count+1 (wraps 255->0), go to IDLE.
- abort=1 in any non-IDLE state: next cycle state=IDLE; cop_req, pix_valid, buf_start=0; frame_count unchanged; done not pulsed.
- Priority on coincident events:
  - abort wins over cop_done.
  - abort wins over pix_ready.
  - reset wins over everything.
- start while busy is ignored.
- Throughput: with cop_wait=0 and pix_ready tied high, each pixel takes 3 cycles (ISSUE, WAIT_RES, OUTPUT) plus the cop_done latency.

Test Plan:
- Preload count: IMG_W=8, IMG_H=4, PIX_PER_WORD=4, size=0 -> buf_start high 4 cycles; (buf_h,buf_v) = (0,0),(4,0),(0,1),(4,1); then cop_req with cop_inst=0x00000005 for mode=5.
- Full frame: cop_done 2 cycles after each req, pix_ready tied high -> 32 pixels in raster order; last cop_inst = {v=3,h=7,mode}; done pulses once; frame_count=1.
- Saturation: mode=5 with result[15:0] = 0xFF80 -> 0x00; 0x0123 -> 0xFF; 0x007A -> 0x7A. mode=7 with result = 0x00400000 -> 0x40.
- Backpressure: pix_ready low for 10 cycles -> pix_valid and pix_data are stable throughout; no new cop_req is issued.
- Abort: assert abort in the same cycle as cop_done -> next cycle IDLE, all outputs 0, no pixel emitted, frame_count unchanged; holding start high does not restart until start goes low then high.
- Reset mid-frame during OUTPUT -> outputs 0 immediately, without waiting for a clock edge; frame_count=0.

Source files
------------

// File: rtl/ipu_frame_sequencer_if.sv
// Signal bundle between the IPU frame sequencer and its neighbours: frame control,
// line-buffer load, convolution coprocessor request/result and the VGA pixel write path.
interface ipu_frame_sequencer_if #(
  parameter int unsigned COORD_W = 9
);
  logic               start;
  logic [1:0]         size;
  logic [3:0]         mode;
  logic               abort;
  logic               busy;
  logic               done;
  logic [7:0]         frame_count;
  logic               buf_start;
  logic [COORD_W-1:0] buf_h;
  logic [COORD_W-1:0] buf_v;
  logic               cop_req;
  logic [31:0]        cop_inst;
  logic               cop_wait;
  logic               cop_done;
  logic [31:0]        cop_result;
  logic               pix_valid;
  logic [7:0]         pix_data;
  logic               pix_ready;

  modport master (
    input  start, size, mode, abort, cop_wait, cop_done, cop_result, pix_ready,
    output busy, done, frame_count, buf_start, buf_h, buf_v, cop_req, cop_inst,
           pix_valid, pix_data
  );

  modport slave (
    output start, size, mode, abort, cop_wait, cop_done, cop_result, pix_ready,
    input  busy, done, frame_count, buf_start, buf_h, buf_v, cop_req, cop_inst,
           pix_valid, pix_data
  );
endinterface

// File: rtl/ipu_frame_sequencer.sv
// Frame sequencer: preloads K line-buffer rows, issues one convolution per output pixel,
// saturates each result to 8 bits and hands it to the VGA path over valid/ready.
module ipu_frame_sequencer #(
  parameter int unsigned IMG_W        = 512,
  parameter int unsigned IMG_H        = 480,
  parameter int unsigned COORD_W      = 9,
  parameter int unsigned PIX_PER_WORD = 4,
  parameter logic [3:0]  CONV_OP      = 4'b0101
) (
  input logic                   clk,
  input logic                   reset,
  ipu_frame_sequencer_if.master io_seq
);
  localparam int unsigned CW1 = COORD_W + 1;
  localparam logic [COORD_W-1:0] H_LAST     = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] V_LAST     = COORD_W'(IMG_H - 1);
  localparam logic [COORD_W-1:0] BUF_H_LAST = COORD_W'(IMG_W - PIX_PER_WORD);
  localparam logic [COORD_W-1:0] BUF_H_STEP = COORD_W'(PIX_PER_WORD);
  localparam logic [CW1-1:0]     BUF_V_END  = CW1'(IMG_H);

  typedef enum logic [2:0] {
    S_IDLE, S_PRELOAD, S_ISSUE, S_WAIT_RES, S_OUTPUT, S_ROWLOAD, S_DONE
  } state_t;

  state_t             r_state,       w_state_nxt;
  logic               r_armed,       w_armed_nxt;
  logic [1:0]         r_size,        w_size_nxt;
  logic [3:0]         r_mode,        w_mode_nxt;
  logic               r_busy,        w_busy_nxt;
  logic               r_done,        w_done_nxt;
  logic [7:0]         r_frame_count, w_frame_count_nxt;
  logic               r_buf_start,   w_buf_start_nxt;
  logic [COORD_W-1:0] r_buf_h,       w_buf_h_nxt;
  logic [COORD_W-1:0] r_buf_v,       w_buf_v_nxt;
  logic [2:0]         r_rows,        w_rows_nxt;
  logic [COORD_W-1:0] r_h_conv,      w_h_conv_nxt;
  logic [COORD_W-1:0] r_v_conv,      w_v_conv_nxt;
  logic               r_cop_req,     w_cop_req_nxt;
  logic [31:0]        r_cop_inst,    w_cop_inst_nxt;
  logic               r_pix_valid,   w_pix_valid_nxt;
  logic [7:0]         r_pix_data,    w_pix_data_nxt;

  logic [15:0]        w_field;
  logic [7:0]         w_sat;
  logic [2:0]         w_k;

  // Result field select and signed 16-bit to unsigned 8-bit clamp
  always_comb begin
    w_field = (r_mode == CONV_OP) ? io_seq.cop_result[15:0] : io_seq.cop_result[31:16];
    if (w_field[15]) begin
      w_sat = 8'h00;
    end else if (w_field[14:8] != 7'd0) begin
      w_sat = 8'hFF;
    end else begin
      w_sat = w_field[7:0];
    end
  end

  assign w_k = 3'(r_size) + 3'd2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_armed       <= 1'b0;
      r_size        <= '0;
      r_mode        <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_frame_count <= '0;
      r_buf_start   <= 1'b0;
      r_buf_h       <= '0;
      r_buf_v       <= '0;
      r_rows        <= '0;
      r_h_conv      <= '0;
      r_v_conv      <= '0;
      r_cop_req     <= 1'b0;
      r_cop_inst    <= '0;
      r_pix_valid   <= 1'b0;
      r_pix_data    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_armed       <= w_armed_nxt;
      r_size        <= w_size_nxt;
      r_mode        <= w_mode_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
      r_frame_count <= w_frame_count_nxt;
      r_buf_start   <= w_buf_start_nxt;
      r_buf_h       <= w_buf_h_nxt;
      r_buf_v       <= w_buf_v_nxt;
      r_rows        <= w_rows_nxt;
      r_h_conv      <= w_h_conv_nxt;
      r_v_conv      <= w_v_conv_nxt;
      r_cop_req     <= w_cop_req_nxt;
      r_cop_inst    <= w_cop_inst_nxt;
      r_pix_valid   <= w_pix_valid_nxt;
      r_pix_data    <= w_pix_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_armed_nxt       = r_armed & io_seq.start;
    w_size_nxt        = r_size;
    w_mode_nxt        = r_mode;
    w_done_nxt        = 1'b0;
    w_frame_count_nxt = r_frame_count;
    w_buf_start_nxt   = r_buf_start;
    w_buf_h_nxt       = r_buf_h;
    w_buf_v_nxt       = r_buf_v;
    w_rows_nxt        = r_rows;
    w_h_conv_nxt      = r_h_conv;
    w_v_conv_nxt      = r_v_conv;
    w_cop_req_nxt     = r_cop_req;
    w_cop_inst_nxt    = r_cop_inst;
    w_pix_valid_nxt   = r_pix_valid;
    w_pix_data_nxt    = r_pix_data;

    case (r_state)
      S_IDLE: begin
        if (io_seq.start && !r_armed) begin
          w_armed_nxt     = 1'b1;
          w_size_nxt      = io_seq.size;
          w_mode_nxt      = io_seq.mode;
          w_buf_start_nxt = 1'b1;
          w_buf_h_nxt     = '0;
          w_buf_v_nxt     = '0;
          w_rows_nxt      = '0;
          w_h_conv_nxt    = '0;
          w_v_conv_nxt    = '0;
          w_state_nxt     = S_PRELOAD;
        end
      end
      S_PRELOAD: begin
        if (r_buf_h == BUF_H_LAST) begin
          w_buf_h_nxt = '0;
          w_buf_v_nxt = r_buf_v + COORD_W'(1);
          w_rows_nxt  = r_rows + 3'd1;
          if (r_rows + 3'd1 == w_k) begin
            w_buf_start_nxt = 1'b0;
            w_state_nxt     = S_ISSUE;
          end
        end else begin
          w_buf_h_nxt = r_buf_h + BUF_H_STEP;
        end
      end
      S_ISSUE: begin
        if (!io_seq.cop_wait) begin
          w_cop_req_nxt  = 1'b1;
          w_cop_inst_nxt = 32'({r_v_conv, r_h_conv, r_mode});
          w_state_nxt    = S_WAIT_RES;
        end
      end
      S_WAIT_RES: begin
        if (io_seq.cop_done) begin
          w_cop_req_nxt   = 1'b0;
          w_pix_valid_nxt = 1'b1;
          w_pix_data_nxt  = w_sat;
          w_state_nxt     = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (io_seq.pix_ready) begin
          w_pix_valid_nxt = 1'b0;
          if (r_h_conv != H_LAST) begin
            w_h_conv_nxt = r_h_conv + COORD_W'(1);
            w_state_nxt  = S_ISSUE;
          end else if (r_v_conv == V_LAST) begin
            w_state_nxt = S_DONE;
          end else begin
            // Next output row needs one more buffered row, if the frame still has one
            w_h_conv_nxt    = '0;
            w_v_conv_nxt    = r_v_conv + COORD_W'(1);
            w_buf_h_nxt     = '0;
            w_buf_start_nxt = ({1'b0, r_buf_v} < BUF_V_END);
            w_state_nxt     = S_ROWLOAD;
          end
        end
      end
      S_ROWLOAD: begin
        if (!r_buf_start) begin
          w_state_nxt = S_ISSUE;
        end else if (r_buf_h == BUF_H_LAST) begin
          w_buf_h_nxt     = '0;
          w_buf_v_nxt     = r_buf_v + COORD_W'(1);
          w_buf_start_nxt = 1'b0;
          w_state_nxt     = S_ISSUE;
        end else begin
          w_buf_h_nxt = r_buf_h + BUF_H_STEP;
        end
      end
      S_DONE: begin
        w_done_nxt        = 1'b1;
        w_frame_count_nxt = r_frame_count + 8'd1;
        w_state_nxt       = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Abort overrides any coincident cop_done/pix_ready and never counts the frame
    if ((r_state != S_IDLE) && io_seq.abort) begin
      w_state_nxt       = S_IDLE;
      w_done_nxt        = 1'b0;
      w_frame_count_nxt = r_frame_count;
      w_buf_start_nxt   = 1'b0;
      w_buf_h_nxt       = '0;
      w_buf_v_nxt       = '0;
      w_cop_req_nxt     = 1'b0;
      w_cop_inst_nxt    = '0;
      w_pix_valid_nxt   = 1'b0;
      w_pix_data_nxt    = '0;
    end

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign io_seq.busy        = r_busy;
  assign io_seq.done        = r_done;
  assign io_seq.frame_count = r_frame_count;
  assign io_seq.buf_start   = r_buf_start;
  assign io_seq.buf_h       = r_buf_h;
  assign io_seq.buf_v       = r_buf_v;
  assign io_seq.cop_req     = r_cop_req;
  assign io_seq.cop_inst    = r_cop_inst;
  assign io_seq.pix_valid   = r_pix_valid;
  assign io_seq.pix_data    = r_pix_data;
endmodule
